// File: rtl/config_loader.sv
// Packet-based loader that turns a header + data word stream into one-hot parameter-memory writes.
// Optional trailing XOR checksum per packet is enabled with CONFIG_LOADER_CHECKSUM_EN.
module config_loader #(
    parameter int DSIZE                   = 16,
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int CONFIG_PARAMETER_NUMBER = 9
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic                                          cfg_valid_i,
    input  logic [31:0]                                   cfg_data_i,
    output logic                                          cfg_ready_o,
    input  logic                                          clear_err_i,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]            config_write_enable_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] config_write_address_o,
    output logic [DSIZE*2-1:0]                            config_data_o,
    output logic                                          busy_o,
    output logic                                          pkt_done_o,
    output logic                                          error_o
);

    localparam int AW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam int DW = DSIZE * 2;
    localparam int NP = CONFIG_PARAMETER_NUMBER;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
`ifdef CONFIG_LOADER_CHECKSUM_EN
        ,
        CHECK = 2'd3
`endif
    } state_e;

    state_e          state_q, state_d;
    logic            ready_q;
    logic [NP-1:0]   we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   nxt_q, nxt_d;
    logic [DW-1:0]   data_q, data_d;
    logic [11:0]     rem_q, rem_d;
    logic [3:0]      sel_q, sel_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            set_err;
    logic            accept;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0]     xor_q, xor_d;
`endif

    logic [3:0]      hdr_sel;
    logic [11:0]     hdr_cnt;
    logic [AW-1:0]   hdr_addr;

    assign hdr_sel  = cfg_data_i[31:28];
    assign hdr_cnt  = cfg_data_i[27:16];
    assign hdr_addr = cfg_data_i[AW-1:0];
    assign accept   = cfg_valid_i & ready_q;

    always_comb begin
        state_d = state_q;
        we_d    = '0;
        addr_d  = addr_q;
        nxt_d   = nxt_q;
        data_d  = data_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        set_err = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_cnt == 12'd0) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d = hdr_sel;
                        rem_d = hdr_cnt;
                        nxt_d = hdr_addr;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        xor_d = '0;
`endif
                        if (32'(hdr_sel) < NP) begin
                            state_d = DATA;
                        end else begin
                            state_d = DRAIN;
                            set_err = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    we_d   = NP'(1) << sel_q;
                    addr_d = nxt_q;
                    nxt_d  = nxt_q + AW'(1);
                    data_d = cfg_data_i[DW-1:0];
                    rem_d  = rem_q - 12'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ cfg_data_i;
                    if (rem_q == 12'd1) state_d = CHECK;
`else
                    if (rem_q == 12'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            DRAIN: begin
                if (accept) begin
                    rem_d = rem_q - 12'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ cfg_data_i;
                    if (rem_q == 12'd1) state_d = CHECK;
`else
                    if (rem_q == 12'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            CHECK: begin
                // Writes already issued stay in memory; a bad checksum only flags the error.
                if (accept) begin
                    if (cfg_data_i != xor_q) set_err = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        err_d = set_err | (err_q & ~clear_err_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            nxt_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            we_q    <= we_d;
            addr_q  <= addr_d;
            nxt_q   <= nxt_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign cfg_ready_o            = ready_q;
    assign config_write_enable_o  = we_q;
    assign config_write_address_o = addr_q;
    assign config_data_o          = data_q;
    assign busy_o                 = (state_q != IDLE);
    assign pkt_done_o             = done_q;
    assign error_o                = err_q;

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter DSIZE, default 16, meaning the neuron datapath width; config data is DSIZE*2 bits.
REQ-002 The block SHALL have parameter NURN_CNT_BIT_WIDTH, default 8, meaning the neuron-ID width.
REQ-003 The block SHALL have parameter AXON_CNT_BIT_WIDTH, default 8, meaning the axon-ID width; write address width AW = NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH.
REQ-004 The block SHALL have parameter CONFIG_PARAMETER_NUMBER, default 9, meaning the number of configurable parameter memories.
REQ-005 The block SHALL have ports as follows, one per line:
 clk_i  in  1  clock
 rst_n_i  in  1  reset, asynchronous, active-low
 cfg_valid_i  in  1  input word valid
 cfg_data_i  in  32  input config word
 cfg_ready_o  out  1  block accepts word
 clear_err_i  in  1  clears sticky error
 config_write_enable_o  out  CONFIG_PARAMETER_NUMBER  one-hot write strobe per parameter memory
 config_write_address_o  out  AW  write address
 config_data_o  out  DSIZE*2  write data
 busy_o  out  1  packet in progress
 pkt_done_o  out  1  one-cycle end-of-packet pulse
 error_o  out  1  sticky error flag

Function
REQ-006 A word SHALL transfer only on a cycle with cfg_valid_i=1 and cfg_ready_o=1.
REQ-007 Header word format SHALL be: [31:28] SEL (parameter select), [27:16] CNT (data-word count, 0-4095), [AW-1:0] start address; header bits [15:AW] are ignored when AW<16.
REQ-008 The FSM states SHALL be IDLE, DATA, DRAIN and CHECK (CHECK exists only with the macro).
REQ-009 In IDLE, cfg_ready_o=1, and an accepted header SHALL transition as follows:
 - CNT=0 -> IDLE, pkt_done_o pulses, no writes.
 - SEL<CONFIG_PARAMETER_NUMBER -> DATA.
 - otherwise -> DRAIN and set error_o.
REQ-010 In DATA, cfg_ready_o=1; the k-th accepted data word (k=0..CNT-1) SHALL produce, exactly one cycle after acceptance, config_write_enable_o = 1<<SEL for one cycle, config_data_o = word[DSIZE*2-1:0], and config_write_address_o = start+k modulo 2^AW (wrap-around permitted).
REQ-011 The strobe, address and data outputs SHALL be registered; config_write_enable_o SHALL be zero on every cycle without a write.
REQ-012 Back-to-back data words SHALL produce back-to-back strobes at full rate.
REQ-013 Gaps in cfg_valid_i SHALL produce no strobe and SHALL leave the address unchanged.
REQ-014 After the CNT-th data word, the FSM SHALL go to IDLE (or CHECK with macro), and pkt_done_o SHALL pulse in the same cycle as the last strobe.
REQ-015 In DRAIN, cfg_ready_o=1; the FSM SHALL accept and discard CNT words with no strobes, then go to IDLE (or CHECK with macro) with a pkt_done_o pulse.
REQ-016 busy_o SHALL be 1 whenever state≠IDLE.
REQ-017 error_o SHALL be sticky and cleared by clear_err_i=1; a set event coincident with clear_err_i SHALL win (error_o stays 1).
REQ-018 A header may be accepted in the cycle immediately following pkt_done_o.

Reset
REQ-019 On rst_n_i low, asynchronously: state=IDLE, cfg_ready_o=0, config_write_enable_o=0, config_write_address_o=0, config_data_o=0, busy_o=0, pkt_done_o=0, error_o=0.
REQ-020 cfg_ready_o SHALL first assert the first clock edge after reset release.
REQ-021 Reset mid-packet SHALL abandon the packet; words following reset are interpreted as a new header.

Configuration
REQ-022 With macro CONFIG_LOADER_CHECKSUM_EN defined, every packet with CNT>0 SHALL carry one trailing word equal to the XOR of all its data words (including DRAIN packets).
 - CHECK accepts that word; a mismatch sets error_o.
 - pkt_done_o pulses on acceptance of the checksum word instead of the last data word.
 - Writes already issued are not retracted.
REQ-023 Without CONFIG_LOADER_CHECKSUM_EN, the CHECK state and XOR logic SHALL be absent, and the word after the last data word SHALL be treated as a header.

Verification
REQ-024 Header SEL=2, CNT=3, addr=0x0010, data 0xA,0xB,0xC back-to-back -> config_write_enable_o=9'h004 on three consecutive cycles, addresses 0x10,0x11,0x12, data 0xA,0xB,0xC; pkt_done_o with the third strobe.
REQ-025 Header SEL=7, CNT=2, addr=0xFFFF, one-cycle valid gap between data words -> addresses 0xFFFF then 0x0000, strobes separated by one idle cycle.
REQ-026 Header SEL=12, CNT=2 plus two words -> no strobes, error_o=1 after header; clear_err_i pulse -> error_o=0.
REQ-027 Header CNT=0 followed immediately by header SEL=0, CNT=1 -> pkt_done_o pulse, then one strobe 9'h001.
REQ-028 rst_n_i asserted after first of 4 data words -> all outputs zero immediately; the next word is parsed as a header.
REQ-029 With CONFIG_LOADER_CHECKSUM_EN: data 0x5,0x3 with checksum 0x6 -> error_o stays 0; with checksum 0x7 -> error_o=1, both writes still issued.
